// File: rtl/abc_mul_n_pkg.sv
// Shared types for the abc_mul_n shift-add multiplier.
// Holds the 3-bit FSM state encoding and the counter width helper clog2().
package abc_mul_n_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REL_IN  = 3'd1,
        S_MUL     = 3'd2,
        S_FIX     = 3'd3,
        S_OUT     = 3'd4,
        S_REL_OUT = 3'd5
    } state_t;

    // Bits needed to hold 0..n-1, never less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/abc_mul_n_if.sv
// Handshake bus of abc_mul_n: two operand producers, one result consumer.
// Ports: dav1_/dav2_/x/y/sgn/rfd3 from the environment; rfd1/rfd2/m/dav3_ from the multiplier.
interface abc_mul_n_if #(parameter int N = 8);

    logic           dav1_;
    logic           dav2_;
    logic           rfd1;
    logic           rfd2;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           sgn;
    logic [2*N-1:0] m;
    logic           dav3_;
    logic           rfd3;

    modport master (
        output dav1_, dav2_, x, y, sgn, rfd3,
        input  rfd1, rfd2, m, dav3_
    );

    modport slave (
        input  dav1_, dav2_, x, y, sgn, rfd3,
        output rfd1, rfd2, m, dav3_
    );

endinterface

// File: rtl/abc_mul_n_add.sv
// N-bit combinational adder used for one shift-add step.
// Ports: a, b operands; s sum; co carry-out.
module abc_mul_n_add #(parameter int N = 8) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/abc_mul_n.sv
// Sequential N-bit shift-add multiplier with optional sign handling.
// Ports: clock, reset_ (async, active low), bus (slave side of abc_mul_n_if).
module abc_mul_n
    import abc_mul_n_pkg::*;
#(
    parameter int N         = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset_,
    abc_mul_n_if.slave bus
);

    localparam int CW = clog2(N);
    localparam logic [N-1:0]   ONE_N  = N'(1);
    localparam logic [2*N-1:0] ONE_2N = (2*N)'(1);
    localparam logic [CW-1:0]  ONE_C  = CW'(1);
    localparam logic [CW-1:0]  LOAD_C = CW'(N - 1);

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic           sgn_q;
    logic           neg;
    logic [2*N-1:0] m_q;
    logic           rfd;
    logic           dav3_o;

    logic           sgn_eff;
    logic [N-1:0]   x_mag;
    logic [N-1:0]   y_mag;
    logic [N-1:0]   addend;
    logic [N-1:0]   sum;
    logic           co;

    // Magnitudes fit in N unsigned bits, including -2^(N-1).
    assign sgn_eff = SIGNED_EN && bus.sgn;
    assign x_mag   = (sgn_eff && bus.x[N-1]) ? (~bus.x + ONE_N) : bus.x;
    assign y_mag   = (sgn_eff && bus.y[N-1]) ? (~bus.y + ONE_N) : bus.y;
    assign addend  = mplier[0] ? mcand : '0;

    abc_mul_n_add #(.N(N)) u_add (
        .a  (acc[2*N-1:N]),
        .b  (addend),
        .s  (sum),
        .co (co)
    );

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (!bus.dav1_ && !bus.dav2_) state_nx = S_REL_IN;
            S_REL_IN:  if (bus.dav1_ && bus.dav2_)   state_nx = S_MUL;
            S_MUL:     if (cnt == '0)                state_nx = S_FIX;
            S_FIX:                                   state_nx = S_OUT;
            S_OUT:     if (!bus.rfd3)                state_nx = S_REL_OUT;
            S_REL_OUT: if (bus.rfd3)                 state_nx = S_IDLE;
            default:                                 state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rfd    = (state == S_IDLE);
        dav3_o = (state != S_OUT);
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            sgn_q  <= 1'b0;
            neg    <= 1'b0;
            m_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!bus.dav1_ && !bus.dav2_) begin
                        mcand  <= x_mag;
                        mplier <= y_mag;
                        sgn_q  <= sgn_eff;
                        neg    <= bus.x[N-1] ^ bus.y[N-1];
                    end
                end
                S_REL_IN: begin
                    if (bus.dav1_ && bus.dav2_) begin
                        cnt <= LOAD_C;
                        acc <= '0;
                    end
                end
                S_MUL: begin
                    // Carry becomes the new MSB as the accumulator shifts right.
                    acc    <= {co, sum, acc[N-1:1]};
                    mplier <= mplier >> 1;
                    if (cnt != '0) cnt <= cnt - ONE_C;
                end
                S_FIX: begin
                    m_q <= (sgn_q && neg) ? (~acc + ONE_2N) : acc;
                end
                default: ;
            endcase
        end
    end

    assign bus.rfd1  = rfd;
    assign bus.rfd2  = rfd;
    assign bus.dav3_ = dav3_o;
    assign bus.m     = m_q;

endmodule

// File: tb/tb_abc_mul_n.sv
// Directed and random bench for abc_mul_n (N=8 signed, N=8 unsigned, N=16).
// Drives the producer/consumer handshakes and checks products and timing.
module tb_abc_mul_n;

    logic clock;
    logic reset_;
    int   total;
    int   passed;
    int   lat;
    int   got;
    logic [31:0] q[$];

    abc_mul_n_if #(.N(8))  bs ();
    abc_mul_n_if #(.N(8))  bu ();
    abc_mul_n_if #(.N(16)) b16 ();

    // The unsigned-only instance runs in lockstep with the signed one.
    assign bu.dav1_ = bs.dav1_;
    assign bu.dav2_ = bs.dav2_;
    assign bu.x     = bs.x;
    assign bu.y     = bs.y;
    assign bu.sgn   = bs.sgn;
    assign bu.rfd3  = bs.rfd3;

    abc_mul_n #(.N(8), .SIGNED_EN(1'b1)) u8 (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bs)
    );

    abc_mul_n #(.N(8), .SIGNED_EN(1'b0)) u8u (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bu)
    );

    abc_mul_n #(.N(16), .SIGNED_EN(1'b1)) u16 (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (b16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input int hold, output int l);
        int n;
        logic [15:0] m0;
        @(negedge clock);
        n = 0;
        while (!bs.rfd1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        bs.x = a;
        bs.y = b;
        bs.sgn = s;
        bs.dav1_ = 1'b0;
        bs.dav2_ = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bs.rfd1 && n < 50);
        bs.dav1_ = 1'b1;
        bs.dav2_ = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bs.dav3_ && n < 100);
        l = n - 1;
        m0 = bs.m;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_dav3", 64'(bs.dav3_), 64'(0));
            chk("hold_m", 64'(bs.m), 64'(m0));
        end
        bs.rfd3 = 1'b0;
        @(negedge clock);
        chk("rel_out_dav3", 64'(bs.dav3_), 64'(1));
        bs.rfd3 = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        total = 0;
        passed = 0;
        reset_ = 1'b0;
        bs.dav1_ = 1'b1;
        bs.dav2_ = 1'b1;
        bs.x = '0;
        bs.y = '0;
        bs.sgn = 1'b0;
        bs.rfd3 = 1'b1;
        b16.dav1_ = 1'b1;
        b16.dav2_ = 1'b1;
        b16.x = '0;
        b16.y = '0;
        b16.sgn = 1'b0;
        b16.rfd3 = 1'b1;

        repeat (2) @(negedge clock);
        chk("rst_rfd1", 64'(bs.rfd1), 64'(1));
        chk("rst_rfd2", 64'(bs.rfd2), 64'(1));
        chk("rst_dav3", 64'(bs.dav3_), 64'(1));
        chk("rst_m", 64'(bs.m), 64'(0));
        chk("rst_m16", 64'(b16.m), 64'(0));
        reset_ = 1'b1;

        do8(8'd13, 8'd11, 1'b0, 0, lat);
        chk("u13x11", 64'(bs.m), 64'(16'd143));
        chk("u13x11_lat", 64'(lat), 64'(9));
        chk("u13x11_uns", 64'(bu.m), 64'(16'd143));

        @(negedge clock);
        bs.dav1_ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("half_dav_rfd1", 64'(bs.rfd1), 64'(1));
        end
        bs.dav1_ = 1'b1;

        do8(8'h80, 8'h80, 1'b1, 10, lat);
        chk("s_m128sq", 64'(bs.m), 64'(16'h4000));
        chk("s_m128sq_uns", 64'(bu.m), 64'(16'h4000));

        do8(8'hFD, 8'h05, 1'b1, 0, lat);
        chk("s_m3x5", 64'(bs.m), 64'(16'hFFF1));
        chk("s_m3x5_lat", 64'(lat), 64'(9));
        chk("s_m3x5_uns", 64'(bu.m), 64'(16'h04F1));

        do8(8'h00, 8'hF9, 1'b1, 0, lat);
        chk("s_0xm7", 64'(bs.m), 64'(0));
        chk("s_0xm7_uns", 64'(bu.m), 64'(0));

        do8(8'hFF, 8'hFF, 1'b0, 0, lat);
        chk("u_ffsq", 64'(bs.m), 64'(16'hFE01));
        chk("u_ffsq_uns", 64'(bu.m), 64'(16'hFE01));

        do8(8'hFF, 8'hFF, 1'b1, 0, lat);
        chk("s_m1sq", 64'(bs.m), 64'(16'h0001));
        chk("ffsq_sgn_ignored", 64'(bu.m), 64'(16'hFE01));

        @(negedge clock);
        bs.x = 8'd13;
        bs.y = 8'd11;
        bs.sgn = 1'b0;
        bs.dav1_ = 1'b0;
        bs.dav2_ = 1'b0;
        @(negedge clock);
        bs.dav1_ = 1'b1;
        bs.dav2_ = 1'b1;
        @(posedge clock);
        repeat (4) @(posedge clock);
        #2 reset_ = 1'b0;
        #1;
        chk("arst_rfd1", 64'(bs.rfd1), 64'(1));
        chk("arst_dav3", 64'(bs.dav3_), 64'(1));
        chk("arst_m", 64'(bs.m), 64'(0));
        chk("arst_m_uns", 64'(bu.m), 64'(0));
        @(negedge clock);
        reset_ = 1'b1;

        do8(8'd2, 8'd3, 1'b0, 0, lat);
        chk("after_rst_2x3", 64'(bs.m), 64'(16'd6));
        chk("after_rst_lat", 64'(lat), 64'(9));

        got = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [15:0] a;
                    logic [15:0] b;
                    logic s;
                    logic signed [31:0] pa;
                    logic signed [31:0] pb;
                    int n;
                    a = 16'($urandom);
                    b = 16'($urandom);
                    s = 1'($urandom_range(0, 1));
                    if (i == 0) begin
                        a = 16'h8000;
                        b = 16'h8000;
                        s = 1'b1;
                    end
                    if (i == 1) begin
                        a = 16'hFFFF;
                        b = 16'hFFFF;
                        s = 1'b0;
                    end
                    if (s) begin
                        pa = 32'($signed(a));
                        pb = 32'($signed(b));
                        q.push_back(32'(pa * pb));
                    end else begin
                        q.push_back({16'd0, a} * {16'd0, b});
                    end
                    @(negedge clock);
                    n = 0;
                    while (!b16.rfd1 && n < 100) begin
                        @(negedge clock);
                        n++;
                    end
                    b16.x = a;
                    b16.y = b;
                    b16.sgn = s;
                    b16.dav1_ = 1'b0;
                    b16.dav2_ = 1'b0;
                    n = 0;
                    do begin
                        @(negedge clock);
                        n++;
                    end while (b16.rfd1 && n < 100);
                    b16.dav1_ = 1'b1;
                    b16.dav2_ = 1'b1;
                end
            end
            begin
                int guard;
                logic [31:0] e;
                guard = 0;
                while (got < 1000 && guard < 60000) begin
                    @(negedge clock);
                    guard++;
                    if (!b16.dav3_ && b16.rfd3) begin
                        e = (q.size() > 0) ? q.pop_front() : 32'hDEADBEEF;
                        chk("r16_prod", 64'(b16.m), 64'(e));
                        got++;
                        b16.rfd3 = 1'b0;
                    end else if (b16.dav3_ && !b16.rfd3) begin
                        b16.rfd3 = 1'b1;
                    end
                end
            end
        join
        chk("r16_count", 64'(got), 64'(1000));
        chk("r16_left", 64'(q.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/abc_mul_n.md
ABC_MUL_N -- requirements
Module: abc_mul_n

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits (N >= 2).
REQ-002 SHALL have parameter SIGNED_EN, default 1; when 0 the sgn input is ignored and all operations are unsigned.
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on posedge.
REQ-004 SHALL have port reset_  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dav1_, dav2_  input  1 each  producer 1/2 data-valid, active low.
REQ-006 SHALL have port rfd1, rfd2  output  1 each  ready-for-data to producer 1/2; always equal.
REQ-007 SHALL have port x, y  input  N each  operands from producer 1/2.
REQ-008 SHALL have port sgn  input  1  1 = two's-complement operands, 0 = natural; driven by producer 1 alongside x.
REQ-009 SHALL have port m  output  2N  product register.
REQ-010 SHALL have port dav3_  output  1  result-valid to consumer, active low.
REQ-011 SHALL have port rfd3  input  1  consumer ready-for-data.

Function
REQ-012 SHALL implement the FSM states S_IDLE, S_REL_IN, S_MUL, S_FIX, S_OUT, S_REL_OUT.
REQ-013 S_IDLE: rfd1=rfd2=1; when dav1_==0 and dav2_==0 on the same edge, SHALL latch x, y, and sgn (sgn forced 0 if SIGNED_EN==0), then go to S_REL_IN; when only one dav_ is low, SHALL stay in S_IDLE and latch nothing.
REQ-014 S_REL_IN: rfd1=rfd2=0; SHALL wait until dav1_==1 and dav2_==1, then go to S_MUL with the step counter loaded with N-1 and the accumulator cleared.
REQ-015 Signed mode: on the latch edge, SHALL store operand magnitudes (two's-complement negation of negative operands) and the result sign neg = x[N-1] XOR y[N-1]; magnitude of -2^(N-1) is 2^(N-1), held in N bits unsigned.
REQ-016 S_MUL: SHALL perform one shift-add step per clock (LSB-first multiplier bit; add multiplicand to accumulator high half when bit = 1; shift right 1 including carry) for exactly N clocks, counter decrementing to 0.
REQ-017 S_FIX: one clock; m SHALL receive the 2N-bit accumulator, negated when signed mode and neg==1; otherwise unchanged.
REQ-018 Latency: S_MUL entry to dav3_==0 SHALL be N+1 clocks.
REQ-019 S_OUT: dav3_=0 and m stable; SHALL wait for rfd3==0, then go to S_REL_OUT.
REQ-020 S_REL_OUT: dav3_=1; SHALL wait for rfd3==1, then go to S_IDLE.
REQ-021 m SHALL change only at the S_FIX edge and SHALL hold its value from then until the next S_FIX.
REQ-022 Producer dav_ activity outside S_IDLE/S_REL_IN SHALL be ignored; no operand is lost, since rfd stays 0.
REQ-023 Product SHALL be exact for all operand pairs; no overflow is possible in 2N bits.

Reset
REQ-024 On reset_==0, immediately and regardless of clock: state=S_IDLE, rfd1=rfd2=1, dav3_=1, m=0, counter=0, accumulator=0.
REQ-025 Reset asserted mid-operation (any state) SHALL abort the operation; no partial result is ever presented.
REQ-026 First active edge after reset_ rises SHALL be evaluated as S_IDLE.

Structure
REQ-027 Shared package SHALL hold the state encoding constants (3-bit) and the counter width function clog2(N).
REQ-028 A single sub-module add, parameter N, with combinational N-bit sum and carry-out, SHALL perform the per-step addition; no other sub-modules.

Verification
REQ-029 N=8, unsigned: x=8'd13, y=8'd11 -> m=16'd143, dav3_ low 9 clocks after S_MUL entry.
REQ-030 N=8, signed: x=-128, y=-128 -> m=16'h4000; x=-3, y=5 -> m=16'hFFF1; x=0, y=-7 -> m=0.
REQ-031 N=8, unsigned: x=y=8'hFF -> m=16'hFE01; SIGNED_EN=0 with sgn=1 gives the same result.
REQ-032 Handshake: dav1_ low, dav2_ high for 5 clocks -> rfd stays 1, no latch; rfd3 held 1 for 10 clocks in S_OUT -> dav3_ stays 0 and m stable.
REQ-033 Reset pulse during S_MUL (counter=3) -> rfd1=1, dav3_=1, m=0 without a clock edge; the next operation 2*3 returns m=6.
REQ-034 N=16 back-to-back: 1000 random signed/unsigned pairs -> every m matches the reference model, and no result is dropped or duplicated.
